wb_sequencer: RTL and testbench
===============================

# wb_sequencer

Write-back sequencer that owns the register file's single write port (reg_write/rd_addr/rd_in plus the car_write/car_in carry port). It merges ALU results (no backpressure) and load results (ready/valid, buffered in a small FIFO) into one registered write stream. It also publishes a pending-write mask for hazard detection. It sits between the execute/memory stages and reg_file.

## Interface
- num_regs, 12, register count; the carry register is index num_regs-1
- reg_width, 8, data width
- fifo_depth, 4, load FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  $clog2(num_regs)  ALU destination register
- alu_data  in  reg_width  ALU result
- alu_car_valid  in  1  carry update accompanies alu_valid
- alu_car  in  reg_width  carry value
- alu_hold  out  1  FIFO full; upstream must not assert alu_valid
- ld_valid  in  1  load result offered
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_rd  in  $clog2(num_regs)  load destination
- ld_data  in  reg_width  load data
- reg_write  out  1  write strobe to reg_file
- rd_addr  out  $clog2(num_regs)  write address
- rd_in  out  reg_width  write data
- car_write  out  1  carry write strobe
- car_in  out  reg_width  carry data
- pend_mask  out  num_regs  bit i set while any FIFO entry targets register i
- err_drop  out  1  sticky; an ALU result was dropped

## Operation
- FIFO: circular buffer, wr/rd pointers plus a count of width $clog2(fifo_depth)+1. Push and pop may happen in the same cycle; the count is then unchanged. Pointers wrap modulo fifo_depth.
- ld_ready = rst_n && (count < fifo_depth). There is no ready-through-pop: a full FIFO refuses loads even when it pops that cycle.
- A load accepted with ld_rd == 0 is consumed but not stored: no push, no write.
- Arbitration per cycle:
  - If count == fifo_depth, the FIFO head wins.
  - Otherwise, if alu_valid, the ALU wins.
  - Otherwise, if count > 0, the head is popped.
  - Otherwise, nothing is issued.
- alu_hold = (count == fifo_depth), combinational.
- If alu_valid is asserted while alu_hold == 1, the result is dropped (no write, no carry) and err_drop is set. err_drop clears only on reset.
- Issue of an ALU result:
  - reg_write = (alu_rd != 0).
  - car_write = alu_car_valid.
  - If alu_rd == num_regs-1 and alu_car_valid, reg_write is forced 0; the carry value wins.
- Issue from the FIFO: reg_write = 1, car_write = 0.
- A non-issuing source keeps its state; a load stays queued.
- pend_mask is recomputed from the valid FIFO entries after each edge. Duplicate targets are ORed.

## Timing
- All write-port outputs are registered. An item selected at edge N drives reg_write/car_write high for the cycle after N, and only for that cycle. reg_file captures it at edge N+1.
- ALU latency: 1 cycle to the strobe. Load latency: at least 2 cycles (enqueue at N, earliest pop at N+1, strobe after N+1). An accepted load never bypasses the FIFO.
- Write order equals issue order. Two FIFO entries to the same register land oldest first.
- Reset values: reg_write=0, car_write=0, rd_addr=0, rd_in=0, car_in=0, err_drop=0, pend_mask=0, alu_hold=0, count=0, pointers=0. ld_ready=0 while rst_n is low.
- Reset mid-operation discards all FIFO entries and any registered write. No strobe issues in the cycle after the reset edge.

## Test plan
- Reset then idle: all outputs 0 for 3 cycles; ld_ready rises the cycle rst_n goes high.
- ALU alu_rd=3, alu_data=8'h5A, alu_car_valid=1, alu_car=8'h01 -> next cycle reg_write=1, rd_addr=3, rd_in=8'h5A, car_write=1, car_in=8'h01, each for one cycle.
- Load ld_rd=5, ld_data=8'hC3 concurrent with ALU alu_rd=2 for 2 cycles -> pend_mask[5]=1 during the ALU writes. The ALU writes to r2 issue first; the r5 write follows with pend_mask[5] then cleared.
- Four loads (r1..r4) while alu_valid is held high -> ld_ready=0 and alu_hold=1 at count 4. The next ALU is dropped and err_drop=1. The FIFO drains r1,r2,r3,r4 in order.
- Load and ALU special cases: load ld_rd=0 is accepted with no write and count unchanged. ALU alu_rd=0 gives reg_write=0. ALU alu_rd=11 with alu_car_valid=1 gives reg_write=0, car_write=1.
- Reset asserted with 3 FIFO entries -> no writes afterwards, pend_mask=0, count=0.

Source files
------------

// File: rtl/wb_sequencer_if.sv
//==============================================================================
// Module      : wb_sequencer_if
// Description : Bundles the write-back sequencer's ALU, load and write-port nets.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface wb_sequencer_if #(
   parameter int NUM_REGS  = 12,
   parameter int REG_WIDTH = 8
);
   localparam int c_addr_w = $clog2(NUM_REGS);

   // ALU result stream (no backpressure beyond alu_hold)
   logic                 alu_valid;
   logic [c_addr_w-1:0]  alu_rd;
   logic [REG_WIDTH-1:0] alu_data;
   logic                 alu_car_valid;
   logic [REG_WIDTH-1:0] alu_car;
   logic                 alu_hold;

   // Load result stream (ready/valid)
   logic                 ld_valid;
   logic                 ld_ready;
   logic [c_addr_w-1:0]  ld_rd;
   logic [REG_WIDTH-1:0] ld_data;

   // Register-file write port and status
   logic                 reg_write;
   logic [c_addr_w-1:0]  rd_addr;
   logic [REG_WIDTH-1:0] rd_in;
   logic                 car_write;
   logic [REG_WIDTH-1:0] car_in;
   logic [NUM_REGS-1:0]  pend_mask;
   logic                 err_drop;

   // The sequencer owns the write port
   modport master (
      input  alu_valid, alu_rd, alu_data, alu_car_valid, alu_car,
      output alu_hold,
      input  ld_valid, ld_rd, ld_data,
      output ld_ready,
      output reg_write, rd_addr, rd_in, car_write, car_in, pend_mask, err_drop
   );

   modport slave (
      output alu_valid, alu_rd, alu_data, alu_car_valid, alu_car,
      input  alu_hold,
      output ld_valid, ld_rd, ld_data,
      input  ld_ready,
      input  reg_write, rd_addr, rd_in, car_write, car_in, pend_mask, err_drop
   );

endinterface : wb_sequencer_if

`default_nettype wire

// File: rtl/wb_sequencer.sv
//==============================================================================
// Module      : wb_sequencer
// Description : Merges ALU and FIFO-buffered load results into one registered
//               register-file write stream and publishes a pending-write mask.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_sequencer #(
   parameter int NUM_REGS   = 12,
   parameter int REG_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   wb_sequencer_if.master    bus
);

   localparam int c_addr_w = $clog2(NUM_REGS);
   localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w  = c_ptr_w + 1;

   localparam logic [c_addr_w-1:0] c_car_idx = c_addr_w'(NUM_REGS - 1);
   localparam logic [c_cnt_w-1:0]  c_full    = c_cnt_w'(FIFO_DEPTH);

   // Load FIFO storage
   logic [c_addr_w-1:0]  r_mem_rd   [FIFO_DEPTH];
   logic [REG_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;

   // Registered write port
   logic                 r_reg_write;
   logic [c_addr_w-1:0]  r_rd_addr;
   logic [REG_WIDTH-1:0] r_rd_in;
   logic                 r_car_write;
   logic [REG_WIDTH-1:0] r_car_in;
   logic                 r_err_drop;

   logic                 w_full;
   logic                 w_ld_ready;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_alu_issue;
   logic                 w_drop;
   logic                 w_alu_reg_we;
   logic [NUM_REGS-1:0]  w_pend;

   assign w_full     = (r_count == c_full);
   assign w_ld_ready = rst_n && !w_full;

   // A load to r0 is handshaken but never stored
   assign w_push = bus.ld_valid && w_ld_ready && (bus.ld_rd != '0);

   // A full FIFO outranks the ALU; otherwise the ALU outranks queued loads
   assign w_alu_issue = bus.alu_valid && !w_full;
   assign w_drop      = bus.alu_valid && w_full;
   assign w_pop       = w_full || (!bus.alu_valid && (r_count != '0));

   // Carry-register target with a carry update: the carry port alone writes it
   assign w_alu_reg_we = (bus.alu_rd != '0) &&
                         !((bus.alu_rd == c_car_idx) && bus.alu_car_valid);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= bus.ld_rd;
         r_mem_data[r_wr_ptr] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_reg_write <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_in     <= '0;
         r_car_write <= 1'b0;
         r_car_in    <= '0;
         r_err_drop  <= 1'b0;
      end else begin
         if (w_drop) begin
            r_err_drop <= 1'b1;
         end
         if (w_alu_issue) begin
            r_reg_write <= w_alu_reg_we;
            r_rd_addr   <= bus.alu_rd;
            r_rd_in     <= bus.alu_data;
            r_car_write <= bus.alu_car_valid;
            r_car_in    <= bus.alu_car;
         end else if (w_pop) begin
            r_reg_write <= 1'b1;
            r_rd_addr   <= r_mem_rd[r_rd_ptr];
            r_rd_in     <= r_mem_data[r_rd_ptr];
            r_car_write <= 1'b0;
         end else begin
            r_reg_write <= 1'b0;
            r_car_write <= 1'b0;
         end
      end
   end

   // Walk the live window from the head; duplicate targets simply OR together
   always_comb begin
      logic [c_ptr_w-1:0] idx;
      w_pend = '0;
      idx    = '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         idx = r_rd_ptr + c_ptr_w'(k);
         if (c_cnt_w'(k) < r_count) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (r_mem_rd[idx] == c_addr_w'(r)) begin
                  w_pend[r] = 1'b1;
               end
            end
         end
      end
   end

   assign bus.alu_hold  = w_full;
   assign bus.ld_ready  = w_ld_ready;
   assign bus.reg_write = r_reg_write;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.rd_in     = r_rd_in;
   assign bus.car_write = r_car_write;
   assign bus.car_in    = r_car_in;
   assign bus.pend_mask = w_pend;
   assign bus.err_drop  = r_err_drop;

endmodule : wb_sequencer

`default_nettype wire

// File: tb/tb_wb_sequencer.sv
//==============================================================================
// Module      : tb_wb_sequencer
// Description : Directed self-checking bench for wb_sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_sequencer;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   wb_sequencer_if #(.NUM_REGS(12), .REG_WIDTH(8)) bus ();

   wb_sequencer #(.NUM_REGS(12), .REG_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it, inputs changed there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [3:0] rd, input logic [7:0] d,
                          input logic cv, input logic [7:0] c);
      bus.alu_valid     = v;
      bus.alu_rd        = rd;
      bus.alu_data      = d;
      bus.alu_car_valid = cv;
      bus.alu_car       = c;
   endtask

   task automatic set_ld(input logic v, input logic [3:0] rd, input logic [7:0] d);
      bus.ld_valid = v;
      bus.ld_rd    = rd;
      bus.ld_data  = d;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [3:0] a,
                         input logic [7:0] d);
      chk({tag, ".we"}, bus.reg_write, we);
      if (we) begin
         chk({tag, ".addr"}, bus.rd_addr, a);
         chk({tag, ".data"}, bus.rd_in, d);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      set_ld(1'b0, 4'd0, 8'h00);

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst.we",    bus.reg_write, 1'b0);
         chk("rst.cw",    bus.car_write, 1'b0);
         chk("rst.addr",  bus.rd_addr,   4'd0);
         chk("rst.data",  bus.rd_in,     8'h00);
         chk("rst.car",   bus.car_in,    8'h00);
         chk("rst.pend",  bus.pend_mask, 12'h000);
         chk("rst.err",   bus.err_drop,  1'b0);
         chk("rst.hold",  bus.alu_hold,  1'b0);
         chk("rst.ready", bus.ld_ready,  1'b0);
      end
      rst_n = 1'b1;
      #1;
      chk("rdy.rise", bus.ld_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle.we", bus.reg_write, 1'b0);
         chk("idle.cw", bus.car_write, 1'b0);
         chk("idle.pend", bus.pend_mask, 12'h000);
      end

      // Single ALU result with carry
      set_alu(1'b1, 4'd3, 8'h5A, 1'b1, 8'h01);
      tick();
      chk_wr("alu1", 1'b1, 4'd3, 8'h5A);
      chk("alu1.cw", bus.car_write, 1'b1);
      chk("alu1.car", bus.car_in, 8'h01);
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      tick();
      chk("alu1.we_off", bus.reg_write, 1'b0);
      chk("alu1.cw_off", bus.car_write, 1'b0);

      // Load concurrent with two ALU results: ALU issues first
      set_ld(1'b1, 4'd5, 8'hC3);
      set_alu(1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
      tick();
      chk_wr("mix.a0", 1'b1, 4'd2, 8'h11);
      chk("mix.pend0", bus.pend_mask, 12'h020);
      set_ld(1'b0, 4'd0, 8'h00);
      set_alu(1'b1, 4'd2, 8'h22, 1'b0, 8'h00);
      tick();
      chk_wr("mix.a1", 1'b1, 4'd2, 8'h22);
      chk("mix.pend1", bus.pend_mask, 12'h020);
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      tick();
      chk_wr("mix.ld", 1'b1, 4'd5, 8'hC3);
      chk("mix.ld.cw", bus.car_write, 1'b0);
      chk("mix.pend2", bus.pend_mask, 12'h000);
      tick();
      chk("mix.idle", bus.reg_write, 1'b0);

      // Fill the FIFO with r1..r4 while the ALU holds the port
      for (int i = 1; i <= 4; i++) begin
         set_ld(1'b1, 4'(i), 8'hD0 + 8'(i));
         set_alu(1'b1, 4'd6, 8'h60 + 8'(i), 1'b0, 8'h00);
         tick();
         chk_wr("fill.alu", 1'b1, 4'd6, 8'h60 + 8'(i));
         chk("fill.ready", bus.ld_ready, (i < 4) ? 1'b1 : 1'b0);
         chk("fill.hold", bus.alu_hold, (i < 4) ? 1'b0 : 1'b1);
      end
      chk("fill.pend", bus.pend_mask, 12'h01E);
      chk("fill.err0", bus.err_drop, 1'b0);
      set_ld(1'b0, 4'd0, 8'h00);
      set_alu(1'b1, 4'd7, 8'h77, 1'b1, 8'hEE);
      tick();
      chk_wr("drain.r1", 1'b1, 4'd1, 8'hD1);
      chk("drop.cw", bus.car_write, 1'b0);
      chk("drop.err", bus.err_drop, 1'b1);
      chk("drain.pend1", bus.pend_mask, 12'h01C);
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk_wr("drain", 1'b1, 4'(i), 8'hD0 + 8'(i));
      end
      chk("drain.pend", bus.pend_mask, 12'h000);
      tick();
      chk("drain.idle", bus.reg_write, 1'b0);
      chk("err.sticky", bus.err_drop, 1'b1);

      // Load to r0: handshaken, never stored
      set_ld(1'b1, 4'd0, 8'hAB);
      tick();
      chk("ld0.we", bus.reg_write, 1'b0);
      chk("ld0.pend", bus.pend_mask, 12'h000);
      chk("ld0.ready", bus.ld_ready, 1'b1);
      set_ld(1'b0, 4'd0, 8'h00);
      tick();
      chk("ld0.nowr", bus.reg_write, 1'b0);

      // ALU to r0, to carry register with and without carry update
      set_alu(1'b1, 4'd0, 8'h44, 1'b0, 8'h00);
      tick();
      chk("alu0.we", bus.reg_write, 1'b0);
      chk("alu0.cw", bus.car_write, 1'b0);
      set_alu(1'b1, 4'd11, 8'h99, 1'b1, 8'h80);
      tick();
      chk("alu11c.we", bus.reg_write, 1'b0);
      chk("alu11c.cw", bus.car_write, 1'b1);
      chk("alu11c.car", bus.car_in, 8'h80);
      set_alu(1'b1, 4'd11, 8'h55, 1'b0, 8'h00);
      tick();
      chk_wr("alu11", 1'b1, 4'd11, 8'h55);
      chk("alu11.cw", bus.car_write, 1'b0);
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      tick();

      // Reset with three queued loads
      for (int i = 7; i <= 9; i++) begin
         set_ld(1'b1, 4'(i), 8'hE0 + 8'(i));
         set_alu(1'b1, 4'd1, 8'h10, 1'b0, 8'h00);
         tick();
      end
      chk("prerst.pend", bus.pend_mask, 12'h380);
      set_ld(1'b0, 4'd0, 8'h00);
      set_alu(1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
      rst_n = 1'b0;
      tick();
      chk("mrst.we", bus.reg_write, 1'b0);
      chk("mrst.pend", bus.pend_mask, 12'h000);
      chk("mrst.err", bus.err_drop, 1'b0);
      chk("mrst.ready", bus.ld_ready, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("postrst.we", bus.reg_write, 1'b0);
         chk("postrst.pend", bus.pend_mask, 12'h000);
         chk("postrst.hold", bus.alu_hold, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_wb_sequencer

`default_nettype wire
